// File: rtl/brightness_pkg.sv
// Shared defaults and width helpers for the PWM brightness controller.
package brightness_pkg;

    localparam int PWM_W_DEF     = 8;
    localparam int LVL_MAX_DEF   = 8;
    localparam int LVL_STEP_DEF  = 32;
    localparam int RST_LVL_DEF   = 4;
    localparam int PRESC_DIV_DEF = 196;

    function automatic int lvl_width(input int lvl_max);
        return (lvl_max < 1) ? 1 : $clog2(lvl_max + 1);
    endfunction

    // Counter width for a 0..div-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/pwm_brightness_ctrl_edge_det.sv
// Rising-edge detector; history register resets to RST_VAL so a level held
// through reset release can be masked.
module edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= RST_VAL;
        else        r_prev <= i_in;
    end

    assign o_rise = i_in & ~r_prev;

endmodule

// File: rtl/pwm_brightness_ctrl.sv
// Button-stepped saturating brightness level driving a glitch-free LED PWM.
module pwm_brightness_ctrl
    import brightness_pkg::*;
#(
    parameter  int PWM_W     = PWM_W_DEF,
    parameter  int LVL_MAX   = LVL_MAX_DEF,
    parameter  int LVL_STEP  = LVL_STEP_DEF,
    parameter  int RST_LVL   = RST_LVL_DEF,
    parameter  int PRESC_DIV = PRESC_DIV_DEF,
    localparam int LVL_W     = lvl_width(LVL_MAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_db,
    input  logic             btn_dn_db,
    output logic             led_pwm,
    output logic [LVL_W-1:0] level
);

    localparam int DUTY_W  = PWM_W + 1;
    localparam int PRESC_W = cnt_width(PRESC_DIV);

    localparam logic [LVL_W-1:0]   LVL_TOP    = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0]   LVL_RST    = LVL_W'(RST_LVL);
    localparam logic [DUTY_W-1:0]  DUTY_RST   = DUTY_W'(RST_LVL * LVL_STEP);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic               w_up_rise;
    logic               w_dn_rise;
    logic               w_tick;
    logic               w_wrap;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [DUTY_W-1:0]  w_duty_nxt;

    logic [LVL_W-1:0]   r_level;
    logic [DUTY_W-1:0]  r_duty;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [PRESC_W-1:0] r_presc;
    logic               r_led;

    edge_det #(.RST_VAL(1'b1)) u_up_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_in   (btn_up_db),
        .o_rise (w_up_rise)
    );

    edge_det #(.RST_VAL(1'b1)) u_dn_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_in   (btn_dn_db),
        .o_rise (w_dn_rise)
    );

    // Saturation is checked before stepping so the level can never wrap.
    always_comb begin
        w_level_nxt = r_level;
        if (w_up_rise && !w_dn_rise && (r_level != LVL_TOP))
            w_level_nxt = r_level + LVL_W'(1);
        else if (w_dn_rise && !w_up_rise && (r_level != '0))
            w_level_nxt = r_level - LVL_W'(1);
    end

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_wrap     = w_tick && (r_pwm_cnt == '1);
    assign w_duty_nxt = DUTY_W'(r_level) * DUTY_W'(LVL_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= LVL_RST;
            r_duty    <= DUTY_RST;
            r_pwm_cnt <= '0;
            r_presc   <= '0;
            r_led     <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            // Duty only changes at the period boundary, so pulses are never cut short.
            if (w_wrap)
                r_duty <= w_duty_nxt;
            r_led <= ({1'b0, r_pwm_cnt} < r_duty);
        end
    end

    assign led_pwm = r_led;
    assign level   = r_level;

endmodule

// File: tb/tb_pwm_brightness_ctrl.sv
// Directed bench for pwm_brightness_ctrl with a 16-clk PWM period.
module tb_pwm_brightness_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_db;
    logic       btn_dn_db;
    logic       led_pwm;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;
    int cyc;

    pwm_brightness_ctrl #(
        .PWM_W(4), .LVL_MAX(4), .LVL_STEP(4), .RST_LVL(2), .PRESC_DIV(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up_db (btn_up_db),
        .btn_dn_db (btn_dn_db),
        .led_pwm   (led_pwm),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; with PRESC_DIV=1 the period starts when cyc%16==0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk_lvl(input string name, input logic [2:0] exp);
        total++;
        if (level !== exp) begin
            bad++;
            $display("FAIL %s: level=%0d expected=%0d", name, level, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic align();
        int n = 0;
        while ((cyc % 16) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ((cyc % 16) != 0) begin
            bad++;
            $display("FAIL align: cyc=%0d expected multiple of 16", cyc);
        end
    endtask

    task automatic count_high(input int n, output int highs, output logic first);
        highs = 0;
        first = 1'bx;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first = led_pwm;
            if (led_pwm === 1'b1) highs++;
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        @(negedge clk);
        btn_up_db = up;
        btn_dn_db = dn;
        repeat (5) @(negedge clk);
        btn_up_db = 1'b0;
        btn_dn_db = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int   h;
        logic f;
        rst_n = 1'b0;
        btn_up_db = 1'b0;
        btn_dn_db = 1'b0;
        repeat (3) @(negedge clk);
        chk_lvl("rst_level", 3'd2);
        chk_int("rst_led", int'(led_pwm), 0);
        rst_n = 1'b1;
        count_high(16, h, f);
        chk_int("rst_first_high", int'(f), 1);
        chk_int("rst_period0_highs", h, 8);
        chk_int("rst_period0_last", int'(led_pwm), 0);
        count_high(16, h, f);
        chk_int("rst_period1_highs", h, 8);
        chk_lvl("rst_level_hold", 3'd2);
    endtask

    task automatic test_up_sat();
        int   h;
        logic f;
        pulse(1'b1, 1'b0);
        chk_lvl("up_1", 3'd3);
        pulse(1'b1, 1'b0);
        chk_lvl("up_2", 3'd4);
        pulse(1'b1, 1'b0);
        chk_lvl("up_sat", 3'd4);
        align();
        count_high(32, h, f);
        chk_int("full_duty_highs", h, 32);
    endtask

    task automatic test_dn_sat();
        int   h;
        logic f;
        logic [2:0] exp_lv [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 1'b1);
            chk_lvl($sformatf("dn_%0d", i), exp_lv[i]);
        end
        align();
        count_high(32, h, f);
        chk_int("zero_duty_highs", h, 0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk_lvl("re_up_2", 3'd2);
        @(negedge clk);
        btn_dn_db = 1'b1;
        repeat (100) @(negedge clk);
        chk_lvl("dn_held", 3'd1);
        btn_dn_db = 1'b0;
        repeat (3) @(negedge clk);
        chk_lvl("dn_released", 3'd1);
    endtask

    task automatic test_both();
        int   h;
        logic f;
        pulse(1'b1, 1'b0);
        chk_lvl("both_pre", 3'd2);
        pulse(1'b1, 1'b1);
        chk_lvl("both_same_clk", 3'd2);
        align();
        count_high(16, h, f);
        chk_int("both_duty_highs", h, 8);
    endtask

    task automatic test_held_reset();
        @(negedge clk);
        btn_up_db = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_lvl("held_through_reset", 3'd2);
        btn_up_db = 1'b0;
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0);
        chk_lvl("held_repress", 3'd3);
    endtask

    task automatic test_midperiod();
        int h0 = 0;
        int h1 = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led_pwm === 1'b1) begin
                if (i < 16) h0++;
                else        h1++;
            end
            if (cyc == 5)  btn_up_db = 1'b1;
            if (cyc == 10) btn_up_db = 1'b0;
        end
        chk_int("mid_cur_period_highs", h0, 8);
        chk_int("mid_next_period_highs", h1, 12);
        chk_lvl("mid_level", 3'd3);
        align();
        repeat (3) @(negedge clk);
        chk_int("pre_async_led", int'(led_pwm), 1);
        rst_n = 1'b0;
        #1;
        chk_int("async_rst_led", int'(led_pwm), 0);
        chk_lvl("async_rst_level", 3'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_sat();
        test_dn_sat();
        test_both();
        test_held_reset();
        test_midperiod();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_brightness_ctrl.md
Name: pwm_brightness_ctrl

Overview:
Consumes the debounced "up" and "down" push-button levels from two debounce wrappers. Detects the rising edge of each button and steps a saturating brightness level. Drives the LED with a glitch-free PWM whose duty is proportional to that level. It sits directly downstream of the switch-debounce stage and is the last stage before the LED pin.

Parameters:
PWM_W, 8, PWM counter width; the PWM period is 2^PWM_W ticks.
LVL_MAX, 8, highest brightness level; levels run 0..LVL_MAX.
LVL_STEP, 32, duty increment per level, in ticks. Constraint: LVL_MAX*LVL_STEP <= 2^PWM_W.
RST_LVL, 4, level loaded on reset. Constraint: RST_LVL <= LVL_MAX.
PRESC_DIV, 196, clk cycles per PWM tick. Minimum 1; a value of 1 gives one tick every clk.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
btn_up_db  input  1  debounced up button, synchronous to clk, active high
btn_dn_db  input  1  debounced down button, synchronous to clk, active high
led_pwm  output  1  registered PWM drive to the LED
level  output  LVL_W  current brightness level, where LVL_W = clog2(LVL_MAX+1)

Behaviour:
- Reset (asynchronous assert, synchronous release via clk):
  - level = RST_LVL; duty_q = RST_LVL*LVL_STEP; pwm_cnt = 0; presc_cnt = 0; led_pwm = 0.
  - Both edge-detect history registers reset to 1, so a button held through reset release never causes a step.
- Edge detect, per button:
  - rise = in & ~prev; prev <= in every clk.
  - Exactly one step per low-to-high transition, regardless of how long the button is held.
- Level update, evaluated at each clk edge:
  - up_rise & ~dn_rise: level + 1, saturating at LVL_MAX.
  - dn_rise & ~up_rise: level - 1, saturating at 0.
  - Both rising in the same cycle: no change.
  - The new level is visible on `level` the cycle after the edge.
- Prescaler:
  - presc_cnt counts 0..PRESC_DIV-1 and wraps.
  - tick = (presc_cnt == PRESC_DIV-1). With PRESC_DIV = 1, tick is constantly 1.
- PWM counter:
  - pwm_cnt (PWM_W bits) increments on tick and wraps from 2^PWM_W-1 to 0.
- Duty register:
  - duty_q (PWM_W+1 bits) is loaded with level*LVL_STEP only on the period boundary, i.e. when tick is 1 and pwm_cnt is 2^PWM_W-1.
  - A level change mid-period therefore takes effect from the next pwm_cnt = 0. No truncated or extra pulses occur.
- Output:
  - led_pwm <= (pwm_cnt < duty_q), registered, so it lags pwm_cnt by one clk.
  - duty_q = 0 gives constant 0.
  - duty_q = 2^PWM_W gives constant 1 with no gap at the wrap.
- Arithmetic:
  - The level*LVL_STEP product is sized to PWM_W+1 bits.
  - Saturation compares are done before the increment/decrement, so level never wraps.
- Reset mid-operation: all registers return to their reset values immediately. PWM restarts at pwm_cnt = 0 with the RST_LVL duty.

Decomposition:
- Shared include/package brightness_pkg:
  - defaults for PWM_W, LVL_MAX, LVL_STEP, RST_LVL, PRESC_DIV;
  - LVL_W derivation.
- One natural sub-module: edge_det (rising-edge detector with parameterised reset value of the history register), instantiated twice.
- The prescaler, PWM counter, level register and duty register stay in pwm_brightness_ctrl.

Test Plan:
Bench parameters for all scenarios: PWM_W=4, LVL_MAX=4, LVL_STEP=4, RST_LVL=2, PRESC_DIV=1, giving a 16-clk period.
1. Reset release, no buttons -> level=2; led_pwm high for exactly 8 of every 16 clks, rising one clk after pwm_cnt=0.
2. Three separate btn_up_db pulses (each 5 clks high, 5 low) -> level goes 3, 4, 4 (saturated); after the next boundary led_pwm is constantly 1 with no low cycle at the wrap.
3. Five btn_dn_db pulses from level 4 -> level goes 3, 2, 1, 0, 0; after the boundary led_pwm is constantly 0. Holding btn_dn_db high for 100 clks produces only one step.
4. btn_up_db and btn_dn_db rise on the same clk at level 2 -> level stays 2 and the duty is unchanged.
5. btn_up_db held high across reset deassertion -> level stays 2. Releasing and re-pressing -> level 3.
6. Up press at pwm_cnt=5 from level 2 -> that period still shows 8 high clks; the following period shows 12. Asserting rst_n=0 mid-period -> led_pwm=0 and level=2 immediately (asynchronously).
